// File: rtl/complex_addsub_pipe.sv
// ---------------------------------------------------------------------------
// complex_addsub_pipe
// Two-stage pipelined complex adder/subtractor (FFT butterfly add/sub element).
// Operands are packed {real, imag}. Each component is a two's-complement
// fixed-point value. The result either saturates or wraps on overflow.
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_valid/o_ready  input handshake; i_sub, i_A, i_B qualify the transfer
//   o_valid/i_ready  output handshake; o_result, o_ovf qualify the transfer
//   o_ovf_sticky     OR of o_ovf over all output transfers since reset/clear
//   i_clr            synchronous clear of o_ovf_sticky (wins over a new ovf)
// ---------------------------------------------------------------------------
module complex_addsub_pipe #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned FRAC_W   = 2,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_sub,
  input  logic [2*DATA_W-1:0] i_A,
  input  logic [2*DATA_W-1:0] i_B,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [2*DATA_W-1:0] o_result,
  output logic [1:0]          o_ovf,
  output logic [1:0]          o_ovf_sticky,
  input  logic                i_clr
);

  localparam int unsigned WORD_W = 2 * DATA_W;
  localparam int unsigned EXT_W  = DATA_W + 1;

  // The fraction width only documents the Q format; catch nonsense settings.
  if (FRAC_W >= DATA_W) begin : g_frac_chk
    $error("complex_addsub_pipe: FRAC_W must be smaller than DATA_W");
  end

  // Stage 1: extended raw sums
  logic             v1_q;
  logic [EXT_W-1:0] re1_q, re1_d;
  logic [EXT_W-1:0] im1_q, im1_d;

  // Stage 2: folded output
  logic              v2_q;
  logic [WORD_W-1:0] res_q, res_d;
  logic [1:0]        ovf_q, ovf_d;
  logic [1:0]        sticky_q, sticky_d;

  logic adv1, adv2;

  // Pipeline advance: a stage may load when it is empty or its contents move on.
  always_comb begin
    adv2    = !v2_q || i_ready;
    adv1    = !v1_q || adv2;
    o_ready = adv1;
  end

  // Sign-extend one component to DATA_W+1 bits.
  function automatic logic [EXT_W-1:0] sext(input logic [DATA_W-1:0] x);
    sext = {x[DATA_W-1], x};
  endfunction

  // Reduce an extended component to DATA_W bits, clamping if enabled.
  function automatic logic [DATA_W-1:0] fold(input logic [EXT_W-1:0] x);
    logic ovf;
    ovf = x[DATA_W] ^ x[DATA_W-1];
    if (SATURATE && ovf) begin
      // Bit DATA_W is the true sign of the unbounded result.
      fold = x[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      fold = x[DATA_W-1:0];
    end
  endfunction

  // Stage 1 arithmetic; real and imag never share a carry.
  always_comb begin
    logic [EXT_W-1:0] a_re, a_im, b_re, b_im;
    a_re  = sext(i_A[WORD_W-1:DATA_W]);
    a_im  = sext(i_A[DATA_W-1:0]);
    b_re  = sext(i_B[WORD_W-1:DATA_W]);
    b_im  = sext(i_B[DATA_W-1:0]);
    re1_d = i_sub ? EXT_W'(a_re - b_re) : EXT_W'(a_re + b_re);
    im1_d = i_sub ? EXT_W'(a_im - b_im) : EXT_W'(a_im + b_im);
  end

  // Stage 2 overflow detection and output folding.
  always_comb begin
    ovf_d = {re1_q[DATA_W] ^ re1_q[DATA_W-1], im1_q[DATA_W] ^ im1_q[DATA_W-1]};
    res_d = {fold(re1_q), fold(im1_q)};
  end

  // Sticky flags: clear has priority over a same-cycle overflowing transfer.
  always_comb begin
    sticky_d = sticky_q;
    if (i_clr) begin
      sticky_d = 2'b00;
    end else if (v2_q && i_ready) begin
      sticky_d = sticky_q | ovf_q;
    end
  end

  // Pipeline registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_q     <= 1'b0;
      re1_q    <= '0;
      im1_q    <= '0;
      v2_q     <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 2'b00;
      sticky_q <= 2'b00;
    end else begin
      if (adv1) begin
        v1_q <= i_valid;
        if (i_valid) begin
          re1_q <= re1_d;
          im1_q <= im1_d;
        end
      end
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          res_q <= res_d;
          ovf_q <= ovf_d;
        end
      end
      sticky_q <= sticky_d;
    end
  end

  assign o_valid      = v2_q;
  assign o_result     = res_q;
  assign o_ovf        = ovf_q;
  assign o_ovf_sticky = sticky_q;

endmodule

// File: tb/tb_complex_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_complex_addsub_pipe
// Self-checking bench: a saturating and a wrapping instance share all inputs.
// A scoreboard queue holds expected results for every accepted input and is
// checked on each output transfer; scenario tasks add directed checks.
// ---------------------------------------------------------------------------
module tb_complex_addsub_pipe;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned WORD_W = 2 * DATA_W;

  logic              clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_valid = 1'b0;
  logic              i_sub = 1'b0;
  logic [WORD_W-1:0] i_A = '0;
  logic [WORD_W-1:0] i_B = '0;
  logic              i_ready = 1'b1;
  logic              i_clr = 1'b0;

  logic              o_ready, o_valid;
  logic [WORD_W-1:0] o_result;
  logic [1:0]        o_ovf, o_ovf_sticky;

  logic              w_ready, w_valid;
  logic [WORD_W-1:0] w_result;
  logic [1:0]        w_ovf, w_sticky;

  always #5 clk = ~clk;

  complex_addsub_pipe #(.DATA_W(DATA_W), .FRAC_W(2), .SATURATE(1'b1)) u_sat (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_sub(i_sub), .i_A(i_A), .i_B(i_B), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_ovf(o_ovf), .o_ovf_sticky(o_ovf_sticky), .i_clr(i_clr)
  );

  complex_addsub_pipe #(.DATA_W(DATA_W), .FRAC_W(2), .SATURATE(1'b0)) u_wrap (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(w_ready),
    .i_sub(i_sub), .i_A(i_A), .i_B(i_B), .o_valid(w_valid), .i_ready(i_ready),
    .o_result(w_result), .o_ovf(w_ovf), .o_ovf_sticky(w_sticky), .i_clr(i_clr)
  );

  typedef struct packed {
    logic [WORD_W-1:0] rs;  // saturating result
    logic [1:0]        ov;  // overflow flags
    logic [WORD_W-1:0] rw;  // wrapping result
  } exp_t;

  exp_t sb_q[$];
  exp_t exp_e;
  int   n_vec = 0;
  int   n_err = 0;

  // Integer-domain reference for one component.
  function automatic void comp_model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                     output logic [7:0] rs, output logic [7:0] rw,
                                     output logic ov);
    int x;
    x  = s ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
    ov = (x > 127) || (x < -128);
    rw = 8'(x);
    if (x > 127)       rs = 8'h7F;
    else if (x < -128) rs = 8'h80;
    else               rs = 8'(x);
  endfunction

  function automatic exp_t model(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b,
                                 input logic s);
    exp_t m;
    logic [7:0] rs_re, rw_re, rs_im, rw_im;
    logic ov_re, ov_im;
    comp_model(a[15:8], b[15:8], s, rs_re, rw_re, ov_re);
    comp_model(a[7:0], b[7:0], s, rs_im, rw_im, ov_im);
    m.rs = {rs_re, rs_im};
    m.rw = {rw_re, rw_im};
    m.ov = {ov_re, ov_im};
    return m;
  endfunction

  // Scoreboard: pop on output transfer, push on input transfer.
  always @(negedge clk) begin
    if (i_rst) begin
      sb_q.delete();
    end else begin
      if (o_valid && i_ready) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got result %h with nothing pending", o_result);
        end else begin
          exp_e = sb_q.pop_front();
          if ({o_result, o_ovf, w_result, w_ovf, w_valid} !==
              {exp_e.rs, exp_e.ov, exp_e.rw, exp_e.ov, 1'b1}) begin
            n_err++;
            $display("FAIL sb_result: got sat %h/%b wrap %h/%b wv %b, expected sat %h/%b wrap %h/%b wv 1",
                     o_result, o_ovf, w_result, w_ovf, w_valid, exp_e.rs, exp_e.ov, exp_e.rw, exp_e.ov);
          end
        end
      end
      if (i_valid && o_ready) sb_q.push_back(model(i_A, i_B, i_sub));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one transaction and hold it until accepted.
  task automatic issue(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b, input logic s);
    bit got;
    got = 0;
    tick();
    i_A = a; i_B = b; i_sub = s; i_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL issue_timeout: o_ready stayed %b, expected 1", o_ready);
    end
    tick();
    i_valid = 1'b0;
  endtask

  // Wait (bounded) until a result is presented; returns at a negedge.
  task automatic wait_out();
    bit got;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_valid) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL wait_out_timeout: o_valid stayed %b, expected 1", o_valid);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({o_valid, o_result, o_ovf, o_ovf_sticky, o_ready} !== {1'b0, 16'h0000, 2'b00, 2'b00, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: got v=%b r=%h ovf=%b st=%b rdy=%b, expected v=0 r=0000 ovf=00 st=00 rdy=1",
               o_valid, o_result, o_ovf, o_ovf_sticky, o_ready);
    end
  endtask

  task automatic test_add();
    i_ready = 1'b1;
    issue(16'h0AEF, 16'h0D16, 1'b0);
    @(negedge clk);
    n_vec++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL add_latency_early: o_valid=%b one cycle after accept, expected 0", o_valid);
    end
    @(negedge clk);
    n_vec++;
    if ({o_valid, o_result, o_ovf} !== {1'b1, 16'h1705, 2'b00}) begin
      n_err++;
      $display("FAIL add_result: got v=%b r=%h ovf=%b, expected v=1 r=1705 ovf=00", o_valid, o_result, o_ovf);
    end
  endtask

  task automatic test_sub();
    issue(16'h0400, 16'h0004, 1'b1);
    wait_out();
    n_vec++;
    if ({o_result, o_ovf, w_result} !== {16'h04FC, 2'b00, 16'h04FC}) begin
      n_err++;
      $display("FAIL sub_result: got r=%h ovf=%b w=%h, expected r=04FC ovf=00 w=04FC", o_result, o_ovf, w_result);
    end
  endtask

  task automatic test_saturation();
    issue(16'h7F00, 16'h0100, 1'b0);
    wait_out();
    n_vec++;
    if ({o_result, o_ovf, w_result, w_ovf} !== {16'h7F00, 2'b10, 16'h8000, 2'b10}) begin
      n_err++;
      $display("FAIL sat_pos: got sat %h/%b wrap %h/%b, expected sat 7F00/10 wrap 8000/10",
               o_result, o_ovf, w_result, w_ovf);
    end
    tick();
    n_vec++;
    if (o_ovf_sticky !== 2'b10) begin
      n_err++;
      $display("FAIL sticky_pos: got %b, expected 10", o_ovf_sticky);
    end
    issue(16'h8000, 16'h0100, 1'b1);
    wait_out();
    n_vec++;
    if ({o_result, o_ovf, w_result, w_ovf} !== {16'h8000, 2'b10, 16'h7F00, 2'b10}) begin
      n_err++;
      $display("FAIL sat_neg: got sat %h/%b wrap %h/%b, expected sat 8000/10 wrap 7F00/10",
               o_result, o_ovf, w_result, w_ovf);
    end
    tick();
    n_vec++;
    if (o_ovf_sticky !== 2'b10) begin
      n_err++;
      $display("FAIL sticky_neg: got %b, expected 10", o_ovf_sticky);
    end
  endtask

  task automatic test_wrap_imag();
    issue(16'h0080, 16'h0080, 1'b0);
    wait_out();
    n_vec++;
    if ({w_result, w_ovf, o_result, o_ovf} !== {16'h0000, 2'b01, 16'h0080, 2'b01}) begin
      n_err++;
      $display("FAIL wrap_imag: got wrap %h/%b sat %h/%b, expected wrap 0000/01 sat 0080/01",
               w_result, w_ovf, o_result, o_ovf);
    end
    tick();
  endtask

  task automatic test_backpressure();
    tick();
    i_ready = 1'b0;
    i_valid = 1'b1; i_sub = 1'b0; i_A = 16'h0101; i_B = 16'h0101;
    @(negedge clk);
    n_vec++;
    if (o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_accept1: o_ready=%b, expected 1", o_ready);
    end
    tick();
    i_A = 16'h0202; i_B = 16'h0202;
    @(negedge clk);
    n_vec++;
    if (o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_accept2: o_ready=%b, expected 1", o_ready);
    end
    tick();
    i_A = 16'h0303; i_B = 16'h0303;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_vec++;
      if ({o_ready, o_valid, o_result} !== {1'b0, 1'b1, 16'h0202}) begin
        n_err++;
        $display("FAIL bp_stall: got rdy=%b v=%b r=%h, expected rdy=0 v=1 r=0202", o_ready, o_valid, o_result);
      end
      tick();
    end
    i_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({o_ready, o_valid, o_result} !== {1'b1, 1'b1, 16'h0202}) begin
      n_err++;
      $display("FAIL bp_drain0: got rdy=%b v=%b r=%h, expected rdy=1 v=1 r=0202", o_ready, o_valid, o_result);
    end
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({o_valid, o_result} !== {1'b1, 16'h0404}) begin
      n_err++;
      $display("FAIL bp_drain1: got v=%b r=%h, expected v=1 r=0404", o_valid, o_result);
    end
    @(negedge clk);
    n_vec++;
    if ({o_valid, o_result} !== {1'b1, 16'h0606}) begin
      n_err++;
      $display("FAIL bp_drain2: got v=%b r=%h, expected v=1 r=0606", o_valid, o_result);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    n_vec++;
    if (o_ovf_sticky !== 2'b11) begin
      n_err++;
      $display("FAIL pre_reset_sticky: got %b, expected 11", o_ovf_sticky);
    end
    i_ready = 1'b0;
    i_valid = 1'b1; i_A = 16'h0101; i_B = 16'h0101;
    tick();
    i_A = 16'h0202; i_B = 16'h0202;
    tick();
    i_valid = 1'b0;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({o_valid, o_ovf_sticky} !== {1'b0, 2'b00}) begin
      n_err++;
      $display("FAIL midflight_reset: got v=%b st=%b, expected v=0 st=00", o_valid, o_ovf_sticky);
    end
    tick();
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_vec++;
      if (o_valid !== 1'b0) begin
        n_err++;
        $display("FAIL stale_after_reset: o_valid=%b r=%h at cycle %0d, expected 0", o_valid, o_result, k);
      end
    end
  endtask

  task automatic test_clear();
    issue(16'h7F7F, 16'h0101, 1'b0);
    wait_out();
    n_vec++;
    if ({o_result, o_ovf} !== {16'h7F7F, 2'b11}) begin
      n_err++;
      $display("FAIL both_ovf: got %h/%b, expected 7F7F/11", o_result, o_ovf);
    end
    tick();
    n_vec++;
    if (o_ovf_sticky !== 2'b11) begin
      n_err++;
      $display("FAIL sticky_both: got %b, expected 11", o_ovf_sticky);
    end
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    n_vec++;
    if (o_ovf_sticky !== 2'b00) begin
      n_err++;
      $display("FAIL clr_sticky: got %b, expected 00", o_ovf_sticky);
    end
    // Overflowing transfer in the same cycle as clear: clear wins.
    i_ready = 1'b0;
    issue(16'h7F00, 16'h0100, 1'b0);
    wait_out();
    tick();
    n_vec++;
    if ({o_valid, o_ovf, o_ovf_sticky} !== {1'b1, 2'b10, 2'b00}) begin
      n_err++;
      $display("FAIL clr_stall_hold: got v=%b ovf=%b st=%b, expected v=1 ovf=10 st=00",
               o_valid, o_ovf, o_ovf_sticky);
    end
    i_ready = 1'b1;
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    n_vec++;
    if ({o_valid, o_ovf_sticky} !== {1'b0, 2'b00}) begin
      n_err++;
      $display("FAIL clr_wins: got v=%b st=%b, expected v=0 st=00", o_valid, o_ovf_sticky);
    end
  endtask

  task automatic test_random_stream();
    for (int k = 0; k < 40; k++) begin
      tick();
      i_ready = 1'($urandom_range(0, 3) != 0);
      i_valid = 1'($urandom_range(0, 1));
      i_sub   = 1'($urandom_range(0, 1));
      i_A     = 16'($urandom);
      i_B     = 16'($urandom);
    end
    tick();
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (4) tick();
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d results still pending, expected 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_saturation();
    test_wrap_imag();
    test_backpressure();
    test_reset_midflight();
    test_clear();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
